wired_lsu_sb_drain: RTL and testbench
=====================================

// Module: wired_lsu_sb_drain
// PURPOSE
// - Drain side of the LSU store buffer: pops committed stores off the 4-entry SB head and retires them.
// - Cache-hit stores go to the dcache data SRAM; uncached or missing stores go to the bus (write-through, no-allocate).
// - Pulses invalid_o to the SB for exactly one cycle per retired entry; sits between SB, dcache SRAM port and bus.
// PARAMETERS
// - WAYS    4   dcache associativity; width of the hit/way one-hot
// - ADDR_W  32  physical address width
// - DATA_W  32  store data width; strobe width is DATA_W/8
// PORTS
// - clk            in   1           clock; all state on posedge
// - rst            in   1           synchronous, active-high reset
// - flush_i        in   1           pipeline flush; drops pending-commit count
// - commit_i       in   1           C stage retired the store at SB head (one per cycle max)
// - head_valid_i   in   1           SB head entry valid
// - head_meta_i    in   sb_meta_t   SB head entry (addr, data, strb, uncached, hit[WAYS-1:0]); hit snoop-updated live
// - invalid_o      out  1           pop SB head this cycle
// - busy_o         out  1           FSM not IDLE or pend_cnt != 0
// - sram_req_o     out  1           SRAM write request
// - sram_way_o     out  WAYS        one-hot target way (= head hit)
// - sram_addr_o    out  ADDR_W      write address
// - sram_data_o    out  DATA_W      write data
// - sram_strb_o    out  DATA_W/8    byte strobes
// - sram_gnt_i     in   1           SRAM accepted the write this cycle
// - bus_req_o      out  1           bus write request (held until bus_gnt_i)
// - bus_addr_o     out  ADDR_W      bus address
// - bus_data_o     out  DATA_W      bus data
// - bus_strb_o     out  DATA_W/8    bus strobes
// - bus_gnt_i      in   1           bus accepted request
// - bus_resp_i     in   1           bus write completed
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, pend_cnt 0.
// - pend_cnt (3b, 0..4): +1 on commit_i, -1 on invalid_o, unchanged if both; commit_i at 4 is illegal (assert).
// - FSM IDLE -> SRAM_WR when pend_cnt!=0 && head_valid_i && !uncached && |hit; -> BUS_REQ on same, else; decision registered.
// - SRAM_WR: sram_req_o=1, payload from head_meta_i; on sram_gnt_i -> DONE.
// - SRAM_WR and head hit clears (snoop eviction) before grant: drop req same cycle, -> BUS_REQ.
// - BUS_REQ: bus_req_o=1, payload stable until bus_gnt_i -> BUS_WAIT; BUS_WAIT: on bus_resp_i -> DONE.
// - DONE: invalid_o=1 for one cycle -> IDLE. Hit store = 3 cycles; bus store = 3 + bus latency.
// - flush_i: pend_cnt<=0; IDLE/SRAM_WR/BUS_REQ/DONE -> IDLE, no invalid_o (SB self-flushes).
// - flush_i in BUS_WAIT: stay until bus_resp_i, then IDLE without invalid_o; busy_o high meanwhile.
// - flush_i with commit_i same cycle: flush wins, pend_cnt=0.
// - rst mid-transaction: immediate IDLE, bus_resp_i for orphaned transaction ignored.
// CONFIGURATION
// - WIRED_SB_DRAIN_FAST_EN defined: IDLE decision combinational, SRAM_WR entered directly in IDLE cycle logic;
// -   invalid_o asserted in the sram_gnt_i cycle, next state IDLE (DONE skipped for SRAM path): 2 cycles/hit store.
// -   Bus path unchanged (still via DONE).
// - Not defined: behaviour as above, 3 cycles/hit store.
// STRUCTURE
// - sb_meta_t, drain FSM state enum, SB_DEPTH=4 in shared wired LSU package alongside the SB definitions.
// - Single module; no sub-module (FSM + 3-bit counter + payload mux only).
// TESTING
// - rst; commit_i x1, head hit=4'b0010 uncached=0, gnt same cycle -> sram_way_o=0010, one invalid_o pulse, pend_cnt 0.
// - uncached head, bus_gnt_i after 2 cycles, bus_resp_i after 5 -> bus_req_o held 2 cycles, invalid_o 1 cycle after resp.
// - 4 commits back-to-back, all hits, gnt always 1 -> 4 invalid_o pulses spaced 3 cycles (2 with FAST_EN); 5th commit asserts.
// - hit cleared while sram_gnt_i=0 in SRAM_WR -> sram_req_o drops, bus_req_o next cycle, exactly one invalid_o.
// - flush_i in BUS_WAIT -> busy_o stays 1, no invalid_o after bus_resp_i, IDLE, pend_cnt 0.
// - commit_i and invalid_o same cycle at pend_cnt=2 -> pend_cnt stays 2.

Source files
------------

// File: rtl/wired_lsu_sb_drain_pkg.sv
// Shared LSU store-buffer definitions used by the store-buffer drain logic.
// Contents: store-buffer depth, the head-entry layout (sb_meta_t), the drain
// FSM state encoding, and a helper that says whether an entry may be written
// straight into the dcache data SRAM.
package wired_lsu_sb_drain_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_WAYS   = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_STRB_W = SB_DATA_W / 8;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_STRB_W-1:0] strb;
        logic                 uncached;
        logic [SB_WAYS-1:0]   hit;
    } sb_meta_t;

    typedef enum logic [2:0] {
        DRN_IDLE     = 3'd0,
        DRN_SRAM_WR  = 3'd1,
        DRN_BUS_REQ  = 3'd2,
        DRN_BUS_WAIT = 3'd3,
        DRN_DONE     = 3'd4
    } drain_state_t;

    // Cacheable and resident in some way: write into the data SRAM.
    function automatic logic sram_eligible(input sb_meta_t m);
        return !m.uncached && (|m.hit);
    endfunction

endpackage

// File: rtl/wired_lsu_sb_drain.sv
// Store-buffer drain: retires committed stores from the SB head.
// Cache hits are written to the dcache data SRAM, everything else goes to the
// bus as a write-through, no-allocate write. invalid_o pops the SB head for
// exactly one cycle per retired entry.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   flush_i                      pipeline flush (drops pending commits)
//   commit_i                     store at SB head committed this cycle
//   head_valid_i, head_meta_i    SB head entry (hit vector is snoop-updated)
//   invalid_o                    pop SB head
//   busy_o                       drain active or commits pending
//   sram_req_o/way/addr/data/strb, sram_gnt_i    dcache data SRAM write port
//   bus_req_o/addr/data/strb, bus_gnt_i, bus_resp_i  bus write port
//
// Build option: WIRED_SB_DRAIN_FAST_EN retires SRAM stores in the grant cycle
// (2 cycles per hit store instead of 3); the bus path is unchanged.
//
// state    | meaning
// IDLE     | waiting for a committed, valid head entry
// SRAM_WR  | requesting the SRAM write for a hitting head
// BUS_REQ  | bus request held with latched payload until granted
// BUS_WAIT | bus accepted, waiting for write response
// DONE     | pop the SB head (one cycle)
module wired_lsu_sb_drain
    import wired_lsu_sb_drain_pkg::*;
#(
    parameter int WAYS   = SB_WAYS,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                commit_i,
    input  logic                head_valid_i,
    input  sb_meta_t            head_meta_i,
    output logic                invalid_o,
    output logic                busy_o,
    output logic                sram_req_o,
    output logic [WAYS-1:0]     sram_way_o,
    output logic [ADDR_W-1:0]   sram_addr_o,
    output logic [DATA_W-1:0]   sram_data_o,
    output logic [DATA_W/8-1:0] sram_strb_o,
    input  logic                sram_gnt_i,
    output logic                bus_req_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_data_o,
    output logic [DATA_W/8-1:0] bus_strb_o,
    input  logic                bus_gnt_i,
    input  logic                bus_resp_i
);

    drain_state_t        state;
    logic [2:0]          pend_cnt;
    logic                flushed_wait;
    logic [ADDR_W-1:0]   bus_addr_q;
    logic [DATA_W-1:0]   bus_data_q;
    logic [DATA_W/8-1:0] bus_strb_q;

    logic head_ok;
    logic sram_ok;
    logic sram_req;
    logic sram_fire;
    logic retire;

    assign head_ok   = (pend_cnt != 3'd0) && head_valid_i;
    assign sram_ok   = sram_eligible(head_meta_i);
    // Hit is watched live: a snoop eviction withdraws the request at once.
    assign sram_req  = (state == DRN_SRAM_WR) && sram_ok && !flush_i;
    assign sram_fire = sram_req && sram_gnt_i;

`ifdef WIRED_SB_DRAIN_FAST_EN
    assign retire = ((state == DRN_DONE) || sram_fire) && !flush_i;
`else
    assign retire = (state == DRN_DONE) && !flush_i;
`endif

    assign invalid_o   = retire;
    assign busy_o      = (state != DRN_IDLE) || (pend_cnt != 3'd0);
    assign sram_req_o  = sram_req;
    assign sram_way_o  = sram_req ? head_meta_i.hit  : '0;
    assign sram_addr_o = sram_req ? head_meta_i.addr : '0;
    assign sram_data_o = sram_req ? head_meta_i.data : '0;
    assign sram_strb_o = sram_req ? head_meta_i.strb : '0;
    assign bus_req_o   = (state == DRN_BUS_REQ);
    assign bus_addr_o  = bus_addr_q;
    assign bus_data_o  = bus_data_q;
    assign bus_strb_o  = bus_strb_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            pend_cnt <= 3'd0;
        end else if (commit_i && !retire) begin
            pend_cnt <= pend_cnt + 3'd1;
        end else if (!commit_i && retire) begin
            pend_cnt <= pend_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DRN_IDLE;
            flushed_wait <= 1'b0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
            bus_strb_q   <= '0;
        end else begin
            case (state)
                DRN_IDLE: begin
                    if (!flush_i && head_ok) begin
                        if (sram_ok) begin
                            state <= DRN_SRAM_WR;
                        end else begin
                            state      <= DRN_BUS_REQ;
                            bus_addr_q <= head_meta_i.addr;
                            bus_data_q <= head_meta_i.data;
                            bus_strb_q <= head_meta_i.strb;
                        end
                    end
                end
                DRN_SRAM_WR: begin
                    if (flush_i) begin
                        state <= DRN_IDLE;
                    end else if (!sram_ok) begin
                        state      <= DRN_BUS_REQ;
                        bus_addr_q <= head_meta_i.addr;
                        bus_data_q <= head_meta_i.data;
                        bus_strb_q <= head_meta_i.strb;
                    end else if (sram_gnt_i) begin
`ifdef WIRED_SB_DRAIN_FAST_EN
                        state <= DRN_IDLE;
`else
                        state <= DRN_DONE;
`endif
                    end
                end
                DRN_BUS_REQ: begin
                    // A grant in the flush cycle leaves a live bus write that
                    // must still be waited out, just without popping the SB.
                    if (bus_gnt_i) begin
                        state        <= DRN_BUS_WAIT;
                        flushed_wait <= flush_i;
                    end else if (flush_i) begin
                        state <= DRN_IDLE;
                    end
                end
                DRN_BUS_WAIT: begin
                    if (bus_resp_i) begin
                        state        <= (flushed_wait || flush_i) ? DRN_IDLE : DRN_DONE;
                        flushed_wait <= 1'b0;
                    end else if (flush_i) begin
                        flushed_wait <= 1'b1;
                    end
                end
                DRN_DONE: begin
                    state <= DRN_IDLE;
                end
                default: begin
                    state <= DRN_IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    commit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(commit_i && (pend_cnt == 3'(SB_DEPTH))));
`endif

endmodule

// File: tb/tb_wired_lsu_sb_drain.sv
module tb_wired_lsu_sb_drain;
    import wired_lsu_sb_drain_pkg::*;

`ifdef WIRED_SB_DRAIN_FAST_EN
    localparam int LAT_HIT = 2;
`else
    localparam int LAT_HIT = 3;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        commit_i = 1'b0;
    logic        head_valid_i = 1'b0;
    sb_meta_t    head_meta_i = '0;
    logic        invalid_o, busy_o, sram_req_o, bus_req_o;
    logic [3:0]  sram_way_o, sram_strb_o, bus_strb_o;
    logic [31:0] sram_addr_o, sram_data_o, bus_addr_o, bus_data_o;
    logic        sram_gnt_i = 1'b0;
    logic        bus_gnt_i = 1'b0;
    logic        bus_resp_i = 1'b0;

    wired_lsu_sb_drain dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .commit_i(commit_i),
        .head_valid_i(head_valid_i), .head_meta_i(head_meta_i),
        .invalid_o(invalid_o), .busy_o(busy_o),
        .sram_req_o(sram_req_o), .sram_way_o(sram_way_o), .sram_addr_o(sram_addr_o),
        .sram_data_o(sram_data_o), .sram_strb_o(sram_strb_o), .sram_gnt_i(sram_gnt_i),
        .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
        .bus_strb_o(bus_strb_o), .bus_gnt_i(bus_gnt_i), .bus_resp_i(bus_resp_i)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: the SB contents as a queue, plus a one-outstanding bus.
    sb_meta_t sb_q[$];
    bit       wr_done = 0;
    bit       bus_out = 0, bus_orphan = 0;
    int       bus_req_age = 0, bus_out_age = 0;
    int       cyc = 0;

    bit       rnd = 0;
    int       sram_gnt_pct = 100;
    int       bus_gnt_lat = 1, bus_resp_lat = 1;
    bit       do_commit = 0, do_flush = 0, do_rst = 0, evict_now = 0, commit_on_inv = 0;
    sb_meta_t commit_meta;

    int       n_inv = 0;
    int       inv_cyc_q[$];
    int       sram_req_first = -1;
    logic [3:0] way_seen = '0;
    int       bus_req_cycles = 0;
    int       resp_cyc = -1;
    bit       last_sram_req = 0, last_bus_req = 0;

    function automatic sb_meta_t rand_meta();
        sb_meta_t m;
        m.addr     = $urandom;
        m.data     = $urandom;
        m.strb     = 4'($urandom_range(15, 1));
        m.uncached = ($urandom_range(3) == 0);
        m.hit      = ($urandom_range(1) == 1) ? (4'b0001 << $urandom_range(3)) : 4'b0000;
        return m;
    endfunction

    function automatic sb_meta_t mk(input logic unc, input logic [3:0] hit);
        sb_meta_t m;
        m = rand_meta();
        m.uncached = unc;
        m.hit = hit;
        return m;
    endfunction

    task automatic clr_obs();
        n_inv = 0;
        inv_cyc_q.delete();
        sram_req_first = -1;
        bus_req_cycles = 0;
        resp_cyc = -1;
    endtask

    // Entered and left at posedge+1: drive, sample at negedge, update model.
    task automatic cycle();
        sb_meta_t nm, hm;
        if (rnd) do_flush = ($urandom_range(99) == 0);
        rst     = do_rst;
        flush_i = do_flush;
        if (evict_now && sb_q.size() != 0) begin
            hm = sb_q[0];
            hm.hit = '0;
            sb_q[0] = hm;
        end
        head_valid_i = (sb_q.size() != 0);
        head_meta_i  = '0;
        if (sb_q.size() != 0) head_meta_i = sb_q[0];
        sram_gnt_i = ($urandom_range(99) < sram_gnt_pct);
        if (rnd) begin
            bus_gnt_i  = bus_req_o && ($urandom_range(1) == 1);
            bus_resp_i = bus_out && ($urandom_range(2) == 0);
        end else begin
            bus_gnt_i  = bus_req_o && (bus_req_age >= bus_gnt_lat - 1);
            bus_resp_i = bus_out && (bus_out_age >= bus_resp_lat - 1);
        end
        #1;
        if (rnd) commit_i = (sb_q.size() < 4) && ($urandom_range(99) < 35);
        else     commit_i = do_commit || (commit_on_inv && invalid_o);
        nm = do_commit ? commit_meta : rand_meta();
        @(negedge clk);
        last_sram_req = sram_req_o;
        last_bus_req  = bus_req_o;
        if (bus_out) begin
            if (bus_resp_i) begin
                bus_out  = 0;
                resp_cyc = cyc;
                if (!bus_orphan) wr_done = 1;
                bus_orphan = 0;
            end else begin
                bus_out_age++;
            end
        end
        if (bus_req_o) bus_req_cycles++;
        if (bus_req_o && bus_gnt_i) begin
            if (!rst) begin
                hm = '0;
                if (sb_q.size() != 0) hm = sb_q[0];
                chk("bus_route", (sb_q.size() != 0) && (hm.uncached || hm.hit == 4'b0), 1);
                chk("bus_payload", {bus_addr_o, bus_data_o, bus_strb_o}, {hm.addr, hm.data, hm.strb});
            end
            bus_out = 1;
            bus_out_age = 0;
            bus_req_age = 0;
        end else if (bus_req_o) begin
            bus_req_age++;
        end else begin
            bus_req_age = 0;
        end
        if (rst) begin
            sb_q.delete();
            wr_done = 0;
            if (bus_out) bus_orphan = 1;
        end else begin
            chk("one_port_at_a_time", sram_req_o && bus_req_o, 0);
            if (sram_req_o) begin
                if (sram_req_first < 0) sram_req_first = cyc;
                way_seen = sram_way_o;
            end
            if (sram_req_o && sram_gnt_i) begin
                hm = '0;
                if (sb_q.size() != 0) hm = sb_q[0];
                chk("sram_route", (sb_q.size() != 0) && !hm.uncached && (hm.hit != 4'b0), 1);
                chk("sram_payload", {sram_addr_o, sram_data_o, sram_strb_o, sram_way_o},
                    {hm.addr, hm.data, hm.strb, hm.hit});
                wr_done = 1;
            end
            if (invalid_o) begin
                n_inv++;
                inv_cyc_q.push_back(cyc);
                chk("retire_after_write", wr_done, 1);
                chk("retire_with_entry", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) void'(sb_q.pop_front());
                wr_done = 0;
            end
            if (commit_i) sb_q.push_back(nm);
            if (flush_i) begin
                sb_q.delete();
                wr_done = 0;
                if (bus_out) bus_orphan = 1;
            end
        end
        cyc++;
        do_commit = 0;
        do_flush  = 0;
        do_rst    = 0;
        evict_now = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            if (!busy_o && sb_q.size() == 0 && !bus_out) done = 1;
            else cycle();
        end
        chk(tag, done, 1);
    endtask

    task automatic commit_one(input sb_meta_t m);
        do_commit   = 1;
        commit_meta = m;
        cycle();
    endtask

    initial begin
        int c0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            do_rst = 1;
            cycle();
        end
        chk("rst_ctrl", {invalid_o, busy_o, sram_req_o, bus_req_o, sram_way_o}, 0);
        chk("rst_sram_payload", {sram_addr_o, sram_data_o, sram_strb_o}, 0);
        chk("rst_bus_payload", {bus_addr_o, bus_data_o, bus_strb_o}, 0);

        // Single hit store, grant in the first request cycle.
        clr_obs();
        c0 = cyc;
        commit_one(mk(1'b0, 4'b0010));
        wait_idle(50, "t1_idle");
        chk("t1_way", way_seen, 4'b0010);
        chk("t1_req_cycle", sram_req_first - c0, 2);
        chk("t1_n_inv", n_inv, 1);
        chk("t1_latency", (inv_cyc_q.size() != 0) ? inv_cyc_q[0] - c0 : -1, LAT_HIT);

        // Uncached store: grant after 2 request cycles, response 5 later.
        clr_obs();
        bus_gnt_lat  = 2;
        bus_resp_lat = 5;
        commit_one(mk(1'b1, 4'b0100));
        wait_idle(60, "t2_idle");
        chk("t2_bus_req_cycles", bus_req_cycles, 2);
        chk("t2_n_inv", n_inv, 1);
        chk("t2_inv_after_resp", (inv_cyc_q.size() != 0) ? inv_cyc_q[0] - resp_cyc : -1, 1);

        // Four back-to-back hit commits.
        clr_obs();
        c0 = cyc;
        for (int i = 0; i < 4; i++) commit_one(mk(1'b0, 4'b0001 << i));
        wait_idle(80, "t3_idle");
        chk("t3_n_inv", n_inv, 4);
        chk("t3_first", (inv_cyc_q.size() != 0) ? inv_cyc_q[0] - c0 : -1, LAT_HIT);
        for (int i = 1; i < 4; i++)
            chk("t3_spacing", (inv_cyc_q.size() > i) ? inv_cyc_q[i] - inv_cyc_q[i-1] : -1, LAT_HIT);

        // Snoop eviction while waiting for the SRAM grant.
        clr_obs();
        sram_gnt_pct = 0;
        bus_gnt_lat  = 1;
        bus_resp_lat = 3;
        commit_one(mk(1'b0, 4'b1000));
        for (int i = 0; i < 10 && sram_req_first < 0; i++) cycle();
        chk("t4_sram_req_seen", sram_req_first >= 0, 1);
        evict_now = 1;
        cycle();
        chk("t4_req_dropped", last_sram_req, 0);
        cycle();
        chk("t4_bus_req_next", last_bus_req, 1);
        sram_gnt_pct = 100;
        wait_idle(40, "t4_idle");
        chk("t4_n_inv", n_inv, 1);

        // Flush while the bus write is outstanding.
        clr_obs();
        bus_resp_lat = 6;
        commit_one(mk(1'b1, 4'b0000));
        for (int i = 0; i < 10 && !bus_out; i++) cycle();
        chk("t5_granted", bus_out, 1);
        do_flush = 1;
        chk("t5_busy_at_flush", busy_o, 1);
        cycle();
        for (int i = 0; i < 20 && bus_out; i++) begin
            chk("t5_busy_held", busy_o, 1);
            cycle();
        end
        chk("t5_resp_seen", bus_out, 0);
        chk("t5_idle", busy_o, 0);
        cycle();
        chk("t5_no_retire", n_inv, 0);

        // Commit coinciding with a retire at two pending entries.
        clr_obs();
        commit_one(mk(1'b0, 4'b0001));
        commit_one(mk(1'b0, 4'b0010));
        commit_on_inv = 1;
        for (int i = 0; i < 10 && n_inv == 0; i++) cycle();
        commit_on_inv = 0;
        chk("t6_first_retire", n_inv, 1);
        chk("t6_sb_after_overlap", sb_q.size(), 2);
        wait_idle(60, "t6_idle");
        chk("t6_n_inv", n_inv, 3);

        // Reset with a bus write in flight; its response must be ignored.
        clr_obs();
        bus_resp_lat = 4;
        commit_one(mk(1'b1, 4'b0010));
        for (int i = 0; i < 10 && !bus_out; i++) cycle();
        do_rst = 1;
        cycle();
        chk("t7_rst_busy", busy_o, 0);
        chk("t7_rst_bus_req", bus_req_o, 0);
        for (int i = 0; i < 10 && bus_out; i++) cycle();
        cycle();
        chk("t7_no_retire", n_inv, 0);
        chk("t7_idle", busy_o, 0);

        // Randomized traffic, then drain.
        clr_obs();
        rnd = 1;
        sram_gnt_pct = 60;
        for (int i = 0; i < 2000; i++) cycle();
        rnd = 0;
        sram_gnt_pct = 100;
        bus_gnt_lat  = 1;
        bus_resp_lat = 2;
        wait_idle(300, "rnd_drain");
        chk("rnd_sb_empty", sb_q.size(), 0);
        chk("rnd_busy", busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
